// File: rtl/ramb16_pkg.sv
//------------------------------------------------------------------------------
// ramb16_pkg
// Shared constants and types for the 4096 x 4 true dual-port block RAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ramb16_pkg;

  localparam int RAMB16_ADDR_W = 12;
  localparam int RAMB16_DATA_W = 4;
  localparam int RAMB16_DEPTH  = 4096;

  typedef logic [RAMB16_ADDR_W-1:0] ramb16_addr_t;
  typedef logic [RAMB16_DATA_W-1:0] ramb16_data_t;

  // Word a port's first output stage takes at an enabled edge.
  // Output reset has priority over write-first, which has priority over read.
  function automatic ramb16_data_t ramb16_first_stage(
    input logic         ssr,
    input logic         we,
    input ramb16_data_t sr_word,
    input ramb16_data_t wdata,
    input ramb16_data_t rdata
  );
    ramb16_data_t word;
    if (ssr) begin
      word = sr_word;
    end else if (we) begin
      word = wdata;
    end else begin
      word = rdata;
    end
    return word;
  endfunction

endpackage : ramb16_pkg

`default_nettype wire

// File: rtl/ramb16_port.sv
//------------------------------------------------------------------------------
// ramb16_port
// Output logic for one RAM port: EN/SSR/WE priority, write-first data
// selection and the registered DO. Optional second output stage selected by
// the RAMB16_OUT_REG_EN macro (2-cycle read latency when defined).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ramb16_port
  import ramb16_pkg::*;
#(
  parameter ramb16_data_t INIT  = '0,
  parameter ramb16_data_t SRVAL = '0
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic         ssr_i,
  input  logic         we_i,
  input  ramb16_data_t di_i,
  input  ramb16_data_t rdata_i,
  output ramb16_data_t do_o
);

`ifdef RAMB16_OUT_REG_EN

  // With the extra stage, SSR clears the first stage and loads SRVAL into
  // the stage that drives DO, so DO shows SRVAL right after the reset edge.
  localparam ramb16_data_t STAGE1_SR = '0;

  ramb16_data_t stage1_d;
  ramb16_data_t stage1_q = '0;
  ramb16_data_t out_d;
  ramb16_data_t out_q = INIT;

  // Next-state for both stages; everything holds while the port is disabled.
  always_comb begin
    stage1_d = stage1_q;
    out_d    = out_q;
    if (en_i) begin
      stage1_d = ramb16_first_stage(ssr_i, we_i, STAGE1_SR, di_i, rdata_i);
      out_d    = ssr_i ? SRVAL : stage1_q;
    end
  end

  // Two-stage output pipeline registers.
  always_ff @(posedge clk_i) begin
    stage1_q <= stage1_d;
    out_q    <= out_d;
  end

  assign do_o = out_q;

`else

  ramb16_data_t out_d;
  ramb16_data_t out_q = INIT;

  // Next-state for the single output register; holds while disabled.
  always_comb begin
    out_d = out_q;
    if (en_i) begin
      out_d = ramb16_first_stage(ssr_i, we_i, SRVAL, di_i, rdata_i);
    end
  end

  // Single output register.
  always_ff @(posedge clk_i) begin
    out_q <= out_d;
  end

  assign do_o = out_q;

`endif

endmodule : ramb16_port

`default_nettype wire

// File: rtl/ramb16_s4_s4.sv
//------------------------------------------------------------------------------
// ramb16_s4_s4
// 16 Kbit true dual-port block RAM, 4096 words x 4 bits, one shared clock.
// Holds the storage array and cross-port collision resolution; the per-port
// output logic lives in ramb16_port. Optional feature macro:
// RAMB16_OUT_REG_EN adds a second output register per port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ramb16_s4_s4
  import ramb16_pkg::*;
#(
  parameter ramb16_data_t INIT_A  = 4'h0,
  parameter ramb16_data_t INIT_B  = 4'h0,
  parameter ramb16_data_t SRVAL_A = 4'h0,
  parameter ramb16_data_t SRVAL_B = 4'h0
) (
  input  logic         CLK,
  input  logic         SSRA,
  input  logic         SSRB,
  input  ramb16_addr_t ADDRA,
  input  ramb16_data_t DIA,
  input  logic         ENA,
  input  logic         WEA,
  output ramb16_data_t DOA,
  input  ramb16_addr_t ADDRB,
  input  ramb16_data_t DIB,
  input  logic         ENB,
  input  logic         WEB,
  output ramb16_data_t DOB
);

  // Storage array. SSR never touches it; only enabled writes change it.
  ramb16_data_t mem_q [RAMB16_DEPTH] = '{default: '0};

  logic         wr_a;
  logic         wr_b;
  ramb16_data_t rdata_a;
  ramb16_data_t rdata_b;

  // A write happens whenever the port is enabled with WE high, even while
  // the port's output reset is asserted.
  assign wr_a = ENA & WEA;
  assign wr_b = ENB & WEB;

  // Reads see the array contents from before this edge, so a port reading
  // an address the other port writes in the same edge gets the old word.
  assign rdata_a = mem_q[ADDRA];
  assign rdata_b = mem_q[ADDRB];

  // Array update. Port A is applied last so it wins a same-address
  // dual-write collision.
  always_ff @(posedge CLK) begin
    if (wr_b) begin
      mem_q[ADDRB] <= DIB;
    end
    if (wr_a) begin
      mem_q[ADDRA] <= DIA;
    end
  end

  ramb16_port #(
    .INIT  (INIT_A),
    .SRVAL (SRVAL_A)
  ) u_port_a (
    .clk_i   (CLK),
    .en_i    (ENA),
    .ssr_i   (SSRA),
    .we_i    (WEA),
    .di_i    (DIA),
    .rdata_i (rdata_a),
    .do_o    (DOA)
  );

  ramb16_port #(
    .INIT  (INIT_B),
    .SRVAL (SRVAL_B)
  ) u_port_b (
    .clk_i   (CLK),
    .en_i    (ENB),
    .ssr_i   (SSRB),
    .we_i    (WEB),
    .di_i    (DIB),
    .rdata_i (rdata_b),
    .do_o    (DOB)
  );

endmodule : ramb16_s4_s4

`default_nettype wire

// File: tb/tb_ramb16_s4_s4.sv
//------------------------------------------------------------------------------
// tb_ramb16_s4_s4
// Directed self-checking bench for the 4096 x 4 dual-port RAM (single
// output register build).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ramb16_s4_s4;

  logic        CLK = 1'b0;
  logic        SSRA, SSRB;
  logic [11:0] ADDRA, ADDRB;
  logic [3:0]  DIA, DIB;
  logic        ENA, ENB, WEA, WEB;
  logic [3:0]  DOA, DOB;

  int tests = 0;
  int fails = 0;

  ramb16_s4_s4 #(
    .INIT_A  (4'hC),
    .INIT_B  (4'h3),
    .SRVAL_A (4'h9),
    .SRVAL_B (4'h6)
  ) dut (
    .CLK   (CLK),
    .SSRA  (SSRA),
    .SSRB  (SSRB),
    .ADDRA (ADDRA),
    .DIA   (DIA),
    .ENA   (ENA),
    .WEA   (WEA),
    .DOA   (DOA),
    .ADDRB (ADDRB),
    .DIB   (DIB),
    .ENB   (ENB),
    .WEB   (WEB),
    .DOB   (DOB)
  );

  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic we, input logic ssr,
                       input logic [11:0] addr, input logic [3:0] di);
    ENA = en; WEA = we; SSRA = ssr; ADDRA = addr; DIA = di;
  endtask

  task automatic set_b(input logic en, input logic we, input logic ssr,
                       input logic [11:0] addr, input logic [3:0] di);
    ENB = en; WEB = we; SSRB = ssr; ADDRB = addr; DIB = di;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    set_a(0, 0, 0, 12'h000, 4'h0);
    set_b(0, 0, 0, 12'h000, 4'h0);
    #1;
    check("init_doa", DOA, 4'hC);
    check("init_dob", DOB, 4'h3);

    // Array starts at zero
    set_a(1, 0, 0, 12'h000, 4'h0);
    set_b(1, 0, 0, 12'hFFF, 4'h0);
    tick();
    check("zero_a", DOA, 4'h0);
    check("zero_b", DOB, 4'h0);

    // Write A, B disabled holds
    set_a(1, 1, 0, 12'h123, 4'hA);
    set_b(0, 0, 0, 12'h000, 4'h0);
    tick();
    check("wr_a_first", DOA, 4'hA);
    check("b_hold", DOB, 4'h0);

    // Read it back on B
    set_a(0, 0, 0, 12'h000, 4'h0);
    set_b(1, 0, 0, 12'h123, 4'h0);
    tick();
    check("rd_b_123", DOB, 4'hA);
    check("a_hold", DOA, 4'hA);

    // Preload 010 = 3
    set_a(1, 1, 0, 12'h010, 4'h3);
    set_b(0, 0, 0, 12'h000, 4'h0);
    tick();
    check("preload", DOA, 4'h3);

    // A writes 7, B reads same address: B gets old word
    set_a(1, 1, 0, 12'h010, 4'h7);
    set_b(1, 0, 0, 12'h010, 4'h0);
    tick();
    check("coll_wr_a", DOA, 4'h7);
    check("coll_old_b", DOB, 4'h3);

    set_a(0, 0, 0, 12'h000, 4'h0);
    tick();
    check("coll_new_b", DOB, 4'h7);

    // Dual write same address: A wins, each DO shows own DI
    set_a(1, 1, 0, 12'hFFF, 4'h5);
    set_b(1, 1, 0, 12'hFFF, 4'hC);
    tick();
    check("dual_wr_doa", DOA, 4'h5);
    check("dual_wr_dob", DOB, 4'hC);

    set_a(1, 0, 0, 12'hFFF, 4'h0);
    set_b(1, 0, 0, 12'hFFF, 4'h0);
    tick();
    check("dual_rd_a", DOA, 4'h5);
    check("dual_rd_b", DOB, 4'h5);

    // SSR with write: DO gets SRVAL, write still lands
    set_a(1, 1, 1, 12'h001, 4'h2);
    set_b(0, 0, 0, 12'h000, 4'h0);
    tick();
    check("ssr_a", DOA, 4'h9);
    check("ssr_b_idle", DOB, 4'h5);

    set_a(1, 0, 0, 12'h001, 4'h0);
    tick();
    check("ssr_wr_kept", DOA, 4'h2);

    // Disabled write on B does nothing
    set_a(0, 0, 0, 12'h000, 4'h0);
    set_b(0, 1, 0, 12'h000, 4'hF);
    tick();
    check("en_low_wr", DOB, 4'h5);

    // Disabled SSR on B does nothing
    set_b(0, 0, 1, 12'h000, 4'h0);
    tick();
    check("en_low_ssr", DOB, 4'h5);

    set_b(1, 0, 0, 12'h000, 4'h0);
    tick();
    check("mem0_untouched", DOB, 4'h0);

    // Enabled SSR read on B
    set_b(1, 0, 1, 12'h123, 4'h0);
    tick();
    check("ssr_b", DOB, 4'h6);

    // SSR did not clear the array
    set_a(1, 0, 0, 12'h123, 4'h0);
    set_b(1, 0, 0, 12'h123, 4'h0);
    tick();
    check("same_rd_a", DOA, 4'hA);
    check("same_rd_b", DOB, 4'hA);

    // Address extremes written on both ports
    set_a(1, 1, 0, 12'h000, 4'h1);
    set_b(1, 1, 0, 12'hFFF, 4'hE);
    tick();
    check("edge_wr_a", DOA, 4'h1);
    check("edge_wr_b", DOB, 4'hE);

    set_a(1, 0, 0, 12'hFFF, 4'h0);
    set_b(1, 0, 0, 12'h000, 4'h0);
    tick();
    check("edge_a_fff", DOA, 4'hE);
    check("edge_b_000", DOB, 4'h1);

    set_a(1, 0, 0, 12'h000, 4'h0);
    set_b(1, 0, 0, 12'hFFF, 4'h0);
    tick();
    check("edge_a_000", DOA, 4'h1);
    check("edge_b_fff", DOB, 4'hE);

    // Disabled SSR on A holds DO
    set_a(0, 0, 1, 12'h000, 4'h0);
    set_b(0, 0, 0, 12'h000, 4'h0);
    tick();
    check("a_ssr_en_low", DOA, 4'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ramb16_s4_s4

`default_nettype wire
